mac_tx_ctrl: RTL and testbench

- TX MAC sequencer FSM, directly upstream of the XGMII frame generator.
- Watches the TX frame buffer (first-word-fall-through, XGMII-formatted lanes) and drives the one-hot generator selects: header, data, error, idle, IFG.
- Drives the buffer read strobe, detects the terminate symbol, and enforces the inter-frame gap.
- Handles buffer underrun and over-length frames by injecting an error beat and flushing the rest of the frame.

---
 rtl/mac_tx_ctrl.sv | 133 +++++++++++++
 tb/tb_mac_tx_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_ctrl.sv
// TX MAC sequencer: walks each buffered frame through header, data and IFG beats, drives the
// generator selects and buffer pops, and turns underrun/over-length frames into error+flush.
module mac_tx_ctrl #(
  parameter int unsigned            N_CHANNELS      = 4,
  parameter int unsigned            W_BYTE          = 8,
  parameter logic [W_BYTE-1:0]      SYM_TERM        = 'hFD,
  parameter int unsigned            N_HDR_BEATS     = 2,
  parameter int unsigned            W_MAC_HDR_CNT   = (N_HDR_BEATS > 1) ? $clog2(N_HDR_BEATS) : 1,
  parameter int unsigned            IFG_BEATS       = 3,
  parameter int unsigned            MAX_FRAME_BEATS = 400,
  parameter int unsigned            W_BEAT_CNT      = 9
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_clk_en,
  input  logic                           i_tx_en,
  input  logic                           i_frame_rdy,
  input  logic                           i_buf_empty,
  input  logic [N_CHANNELS-1:0]          i_buf_rctrl,
  input  logic [N_CHANNELS*W_BYTE-1:0]   i_buf_rdata,
  output logic                           o_buf_ren,
  output logic                           o_gen_hdr,
  output logic [W_MAC_HDR_CNT-1:0]       o_hdr_id,
  output logic                           o_gen_data,
  output logic                           o_gen_error,
  output logic                           o_gen_idle,
  output logic                           o_gen_ifg,
  output logic                           o_frame_done,
  output logic                           o_underrun,
  output logic                           o_busy
);

  localparam int unsigned W_IFG_CNT = (IFG_BEATS > 1) ? $clog2(IFG_BEATS) : 1;

  localparam logic [W_MAC_HDR_CNT-1:0] HDR_LAST = W_MAC_HDR_CNT'(N_HDR_BEATS - 1);
  localparam logic [W_BEAT_CNT-1:0]    BEAT_MAX = W_BEAT_CNT'(MAX_FRAME_BEATS);
  localparam logic [W_IFG_CNT-1:0]     IFG_LAST = W_IFG_CNT'(IFG_BEATS - 1);

  typedef enum logic [2:0] {StIdle, StHdr, StData, StFlush, StIfg} state_e;

  state_e                   state_q;
  logic [W_MAC_HDR_CNT-1:0] hdr_cnt_q;
  logic [W_BEAT_CNT-1:0]    beat_cnt_q;
  logic [W_IFG_CNT-1:0]     ifg_cnt_q;

  logic term;
  logic abort;
  logic data_ok;
  logic pop;

  always_comb begin
    term = 1'b0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (i_buf_rctrl[i] && (i_buf_rdata[i*W_BYTE +: W_BYTE] == SYM_TERM)) begin
        term = 1'b1;
      end
    end
  end

  // Underrun and watchdog share one response; DATA turns into an error beat in the same cycle
  // so the generator never sends a data beat without a matching pop.
  assign abort   = (state_q == StData) && (i_buf_empty || (beat_cnt_q == BEAT_MAX));
  assign data_ok = (state_q == StData) && !abort;
  assign pop     = data_ok || ((state_q == StFlush) && !i_buf_empty);

  assign o_gen_idle   = (state_q == StIdle) || (state_q == StFlush);
  assign o_gen_hdr    = (state_q == StHdr);
  assign o_gen_data   = data_ok;
  assign o_gen_error  = abort;
  assign o_gen_ifg    = (state_q == StIfg);
  assign o_hdr_id     = hdr_cnt_q;
  assign o_busy       = (state_q != StIdle);
  assign o_buf_ren    = pop && i_clk_en;
  assign o_frame_done = data_ok && term && i_clk_en;
  assign o_underrun   = abort && i_clk_en;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      hdr_cnt_q  <= '0;
      beat_cnt_q <= '0;
      ifg_cnt_q  <= '0;
    end else if (i_clk_en) begin
      unique case (state_q)
        StIdle: begin
          if (i_tx_en && i_frame_rdy) begin
            state_q   <= StHdr;
            hdr_cnt_q <= '0;
          end
        end
        StHdr: begin
          if (hdr_cnt_q == HDR_LAST) begin
            state_q    <= StData;
            beat_cnt_q <= '0;
          end else begin
            hdr_cnt_q <= hdr_cnt_q + 1'b1;
          end
        end
        StData: begin
          if (abort) begin
            state_q <= StFlush;
          end else begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (term) begin
              state_q   <= StIfg;
              ifg_cnt_q <= '0;
            end
          end
        end
        StFlush: begin
          if (!i_buf_empty && term) begin
            state_q   <= StIfg;
            ifg_cnt_q <= '0;
          end
        end
        StIfg: begin
          if (ifg_cnt_q == IFG_LAST) begin
            if (i_tx_en && i_frame_rdy) begin
              state_q   <= StHdr;
              hdr_cnt_q <= '0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            ifg_cnt_q <= ifg_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_ctrl.sv
// Randomized scoreboard bench for mac_tx_ctrl: a frame-level model predicts every non-idle beat,
// a monitor compares what the DUT presents on each enabled beat.
module tb_mac_tx_ctrl;

  localparam int NCH  = 4;
  localparam int WB   = 8;
  localparam int NHDR = 2;
  localparam int WHID = 1;
  localparam int IFG  = 3;
  localparam int MAXB = 8;
  localparam int WBC  = 4;
  localparam logic [7:0] TERM = 8'hFD;

  localparam logic [2:0] SelHdr   = 3'd1;
  localparam logic [2:0] SelData  = 3'd2;
  localparam logic [2:0] SelErr   = 3'd3;
  localparam logic [2:0] SelFlush = 3'd4;
  localparam logic [2:0] SelIfg   = 3'd5;

  typedef struct packed {
    logic [NCH-1:0]    ctrl;
    logic [NCH*WB-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [2:0]      sel;
    logic [WHID-1:0] hid;
    logic            ren;
    logic            done;
    logic            und;
    logic            gap;
  } rec_t;

  logic              i_clk;
  logic              i_reset_n;
  logic              i_clk_en;
  logic              i_tx_en;
  logic              i_frame_rdy;
  logic              i_buf_empty;
  logic [NCH-1:0]    i_buf_rctrl;
  logic [NCH*WB-1:0] i_buf_rdata;
  logic              o_buf_ren;
  logic              o_gen_hdr;
  logic [WHID-1:0]   o_hdr_id;
  logic              o_gen_data;
  logic              o_gen_error;
  logic              o_gen_idle;
  logic              o_gen_ifg;
  logic              o_frame_done;
  logic              o_underrun;
  logic              o_busy;

  mac_tx_ctrl #(
    .N_CHANNELS     (NCH),
    .W_BYTE         (WB),
    .SYM_TERM       (TERM),
    .N_HDR_BEATS    (NHDR),
    .W_MAC_HDR_CNT  (WHID),
    .IFG_BEATS      (IFG),
    .MAX_FRAME_BEATS(MAXB),
    .W_BEAT_CNT     (WBC)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_clk_en    (i_clk_en),
    .i_tx_en     (i_tx_en),
    .i_frame_rdy (i_frame_rdy),
    .i_buf_empty (i_buf_empty),
    .i_buf_rctrl (i_buf_rctrl),
    .i_buf_rdata (i_buf_rdata),
    .o_buf_ren   (o_buf_ren),
    .o_gen_hdr   (o_gen_hdr),
    .o_hdr_id    (o_hdr_id),
    .o_gen_data  (o_gen_data),
    .o_gen_error (o_gen_error),
    .o_gen_idle  (o_gen_idle),
    .o_gen_ifg   (o_gen_ifg),
    .o_frame_done(o_frame_done),
    .o_underrun  (o_underrun),
    .o_busy      (o_busy)
  );

  beat_t bufq[$];
  rec_t  expq[$];

  int n_pass        = 0;
  int n_total       = 0;
  int rec_cnt       = 0;
  int pops_in_frame = 0;
  int starve_after  = -1;
  bit ce_toggle     = 1'b0;
  bit smp_ren       = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit q_has_term();
    for (int k = 0; k < bufq.size(); k++) begin
      for (int l = 0; l < NCH; l++) begin
        if (bufq[k].ctrl[l] && bufq[k].data[l*WB +: WB] == TERM) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Frame-level reference: builds the buffer contents and the beat stream the DUT must present.
  task automatic push_frame(input int len, input int starve, input bit b2b, input int lane);
    beat_t b;
    rec_t  r;
    int    lim;
    int    tl;
    for (int j = 0; j < len; j++) begin
      b.ctrl = NCH'($urandom);
      b.data = $urandom;
      for (int l = 0; l < NCH; l++) begin
        if (b.ctrl[l] && b.data[l*WB +: WB] == TERM) b.data[l*WB +: WB] = 8'h07;
      end
      if (j == len - 1) begin
        tl = (lane < 0) ? int'($urandom_range(0, NCH - 1)) : lane;
        b.ctrl[tl] = 1'b1;
        b.data[tl*WB +: WB] = TERM;
      end
      bufq.push_back(b);
    end
    for (int h = 0; h < NHDR; h++) begin
      r = '0; r.sel = SelHdr; r.hid = WHID'(h); r.gap = (h == 0) && !b2b;
      expq.push_back(r);
    end
    lim = MAXB;
    if (starve >= 0 && starve < lim) lim = starve;
    if (starve >= 0) begin
      pops_in_frame = 0;
      starve_after  = starve;
    end
    if (len <= lim) begin
      for (int j = 0; j < len; j++) begin
        r = '0; r.sel = SelData; r.ren = 1'b1; r.done = (j == len - 1);
        expq.push_back(r);
      end
    end else begin
      for (int j = 0; j < lim; j++) begin
        r = '0; r.sel = SelData; r.ren = 1'b1;
        expq.push_back(r);
      end
      r = '0; r.sel = SelErr; r.und = 1'b1;
      expq.push_back(r);
      for (int j = lim; j < len; j++) begin
        r = '0; r.sel = SelFlush; r.ren = 1'b1;
        expq.push_back(r);
      end
    end
    for (int k = 0; k < IFG; k++) begin
      r = '0; r.sel = SelIfg;
      expq.push_back(r);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((expq.size() != 0 || o_busy) && n < 2000) begin
      @(posedge i_clk); #1;
      n++;
    end
    check({name, "_drain"}, expq.size(), 0);
    check({name, "_idle"}, o_busy, 0);
    repeat (2) @(posedge i_clk);
  endtask

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Buffer model and input driver: inputs change on the falling edge, pops follow the sampled ren.
  initial begin
    bit starving;
    i_clk_en = 1'b1; i_tx_en = 1'b0; i_frame_rdy = 1'b0; i_buf_empty = 1'b1;
    i_buf_rctrl = '0; i_buf_rdata = '0;
    forever begin
      @(negedge i_clk);
      if (smp_ren && bufq.size() > 0) begin
        void'(bufq.pop_front());
        pops_in_frame++;
      end
      i_clk_en    = ce_toggle ? ~i_clk_en : 1'b1;
      starving    = (starve_after >= 0) && (pops_in_frame == starve_after) && o_busy && !o_gen_hdr;
      i_buf_empty = starving || (bufq.size() == 0);
      i_buf_rctrl = (bufq.size() > 0) ? bufq[0].ctrl : '0;
      i_buf_rdata = (bufq.size() > 0) ? bufq[0].data : '0;
      i_frame_rdy = q_has_term();
      #4;
      smp_ren = o_buf_ren;
      if (starving && i_clk_en) starve_after = -1;
    end
  end

  // Monitor: every enabled beat that is not plain idle must match the head of the scoreboard.
  initial begin
    bit   gap = 1'b1;
    rec_t a;
    rec_t e;
    forever begin
      @(negedge i_clk); #4;
      check("onehot", $countones({o_gen_hdr, o_gen_data, o_gen_error, o_gen_idle, o_gen_ifg}), 1);
      if (!i_reset_n) begin
        gap = 1'b1;
      end else if (!i_clk_en) begin
        check("ren_gated", o_buf_ren, 0);
      end else if (!o_gen_idle || o_buf_ren) begin
        a = '0;
        a.sel = o_gen_hdr ? SelHdr : o_gen_data ? SelData : o_gen_error ? SelErr :
                o_gen_ifg ? SelIfg : SelFlush;
        a.hid  = o_gen_hdr ? o_hdr_id : '0;
        a.ren  = o_buf_ren;
        a.done = o_frame_done;
        a.und  = o_underrun;
        a.gap  = gap;
        if (expq.size() > 0) e = expq.pop_front();
        else e = '1;
        check("beat", 64'(a), 64'(e));
        rec_cnt++;
        gap = 1'b0;
      end else begin
        gap = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int base;
    int n;
    int len;
    int kind;
    i_reset_n = 1'b0;
    #1;
    check("reset_outputs", {o_buf_ren, o_gen_hdr, o_hdr_id, o_gen_data, o_gen_error, o_gen_idle,
                            o_gen_ifg, o_frame_done, o_underrun, o_busy}, 10'b0000010000);
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (2) @(posedge i_clk); #1;
    i_tx_en = 1'b1;

    push_frame(4, -1, 1'b0, 2);
    wait_idle("normal");
    push_frame(1, -1, 1'b0, -1);
    wait_idle("len1");
    push_frame(MAXB, -1, 1'b0, -1);
    wait_idle("len_max");

    push_frame(6, 2, 1'b0, -1);
    wait_idle("underrun");
    push_frame(3, 0, 1'b0, -1);
    wait_idle("underrun_first");

    push_frame(12, -1, 1'b0, -1);
    wait_idle("watchdog");
    push_frame(MAXB + 1, -1, 1'b0, -1);
    wait_idle("watchdog_edge");

    ce_toggle = 1'b1;
    push_frame(4, -1, 1'b0, 2);
    wait_idle("clk_en");
    ce_toggle = 1'b0;
    repeat (2) @(posedge i_clk); #1;

    push_frame(3, -1, 1'b0, -1);
    push_frame(5, -1, 1'b1, -1);
    push_frame(1, -1, 1'b1, -1);
    wait_idle("b2b");

    i_tx_en = 1'b0;
    base = rec_cnt;
    push_frame(2, -1, 1'b0, -1);
    repeat (20) @(posedge i_clk); #1;
    check("txen_hold_beats", rec_cnt - base, 0);
    check("txen_hold_busy", o_busy, 0);
    i_tx_en = 1'b1;
    wait_idle("txen_start");

    push_frame(6, -1, 1'b0, -1);
    n = 0;
    while (!o_busy && n < 100) begin
      @(posedge i_clk); #1;
      n++;
    end
    i_tx_en = 1'b0;
    wait_idle("txen_drop");
    i_tx_en = 1'b1;

    for (int i = 0; i < 14; i++) begin
      kind = int'($urandom_range(0, 2));
      if (kind == 0) begin
        push_frame(int'($urandom_range(1, MAXB)), -1, 1'b0, -1);
      end else if (kind == 1) begin
        len = int'($urandom_range(2, MAXB));
        push_frame(len, int'($urandom_range(0, len - 1)), 1'b0, -1);
      end else begin
        push_frame(int'($urandom_range(MAXB + 1, MAXB + 6)), -1, 1'b0, -1);
      end
      wait_idle("random");
    end

    // Reset during the second data beat, then a fresh frame must start from header beat 0.
    push_frame(6, -1, 1'b0, -1);
    while (expq.size() > 3) void'(expq.pop_back());
    base = rec_cnt;
    n = 0;
    while (rec_cnt < base + 3 && n < 200) begin
      @(posedge i_clk);
      n++;
    end
    #1;
    i_reset_n = 1'b0;
    #1;
    check("rst_mid_idle", o_gen_idle, 1);
    check("rst_mid_ren", o_buf_ren, 0);
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_seen", expq.size(), 0);
    bufq.delete();
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    push_frame(4, -1, 1'b0, -1);
    wait_idle("after_reset");

    check("final_queue", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
